// File: rtl/rsfq_drv_pkg.sv
// Shared types and defaults for the RSFQ two-input AND gate driver.
package rsfq_drv_pkg;

    localparam int SETUP_CYC_DEF = 4;
    localparam int RESP_CYC_DEF  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_SETUP,
        ST_CLKP,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Two-bit saturating toggle counter: 0, 1, or "two or more".
    function automatic logic [1:0] sat_inc2(input logic [1:0] v, input logic inc);
        return (inc && v != 2'd2) ? v + 2'd1 : v;
    endfunction

endpackage

// File: rtl/rsfq_toggle_det.sv
// Converts a toggle-encoded SFQ line into one-cycle pulses and flags unknown levels.
module rsfq_toggle_det (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic pulse,
    output logic unknown
);

    logic prev;

    assign unknown = $isunknown(line);
    assign pulse   = !unknown && (line != prev);

    // Track the last known level; an unknown sample leaves the reference untouched.
    always_ff @(posedge clk) begin
        // NOTE: reset loads the live level so leaving reset never reports a false edge.
        if (!rst_n) begin
            prev <= line;
        end else if (!unknown) begin
            prev <= line;
        end
    end

endmodule

// File: rtl/rsfq_and2t_driver.sv
// Drives one RSFQ AND2 gate: data pulses, a clock pulse, then a timed response window.
module rsfq_and2t_driver
    import rsfq_drv_pkg::*;
#(
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int RESP_CYC  = RESP_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_a,
    input  logic req_b,
    output logic sfq_a,
    output logic sfq_b,
    output logic sfq_clk,
    input  logic sfq_out,
    output logic rsp_valid,
    output logic rsp_q,
    output logic rsp_err
);

    localparam int CNT_W = $clog2(SETUP_CYC + RESP_CYC + 1);
    // SETUP runs SETUP_CYC-1 cycles, so its last count is SETUP_CYC-2.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYC > 1) ? SETUP_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_CYC - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             a_q, b_q;
    logic [1:0]       tog_cnt, tog_final;
    logic             spur, x_seen;
    logic             det_pulse, det_unknown;
    logic             accept, pre_wait, q_final, err_final;

    rsfq_toggle_det u_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .line   (sfq_out),
        .pulse  (det_pulse),
        .unknown(det_unknown)
    );

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign pre_wait  = (state == ST_IDLE) || (state == ST_DATA) ||
                       (state == ST_SETUP) || (state == ST_CLKP);

    // Result as it will be reported: includes a toggle landing on the last WAIT cycle.
    assign tog_final = sat_inc2(tog_cnt, det_pulse);
    assign q_final   = (tog_final != 2'd0);
    assign err_final = (q_final != (a_q & b_q)) || (tog_final == 2'd2) ||
                       x_seen || det_unknown || spur;

    // Next-state and phase counter.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE:  if (accept) state_next = ST_DATA;
            ST_DATA: begin
                cnt_next   = '0;
                state_next = (SETUP_CYC == 1) ? ST_CLKP : ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt == SETUP_LAST) state_next = ST_CLKP;
                else                   cnt_next   = cnt + 1'b1;
            end
            ST_CLKP: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == RESP_LAST) state_next = ST_RESP;
                else                  cnt_next   = cnt + 1'b1;
            end
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, pulse lines, toggle bookkeeping and the held response.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every register reads pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            sfq_a     <= 1'b0;
            sfq_b     <= 1'b0;
            sfq_clk   <= 1'b0;
            tog_cnt   <= 2'd0;
            spur      <= 1'b0;
            x_seen    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_q     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;

            // Data toggles land on the edge into DATA, so they are visible during DATA.
            if (accept) begin
                a_q   <= req_a;
                b_q   <= req_b;
                sfq_a <= sfq_a ^ req_a;
                sfq_b <= sfq_b ^ req_b;
            end

            // CLKP lasts one cycle, so this fires exactly once per operation.
            if (state_next == ST_CLKP) sfq_clk <= ~sfq_clk;

            if (state == ST_WAIT)      tog_cnt <= tog_final;
            else if (state == ST_RESP) tog_cnt <= 2'd0;

            // Sticky flags survive until the response that reports them.
            if (state == ST_RESP) begin
                spur   <= 1'b0;
                x_seen <= 1'b0;
            end else begin
                if (det_pulse && pre_wait) spur   <= 1'b1;
                if (det_unknown)           x_seen <= 1'b1;
            end

            rsp_valid <= (state_next == ST_RESP);
            if (state == ST_WAIT && state_next == ST_RESP) begin
                rsp_q   <= q_final;
                rsp_err <= err_final;
            end
        end
    end

endmodule

// File: tb/tb_rsfq_and2t_driver.sv
// Self-checking bench: directed vector table, back-to-back, reset abort, random ops.
module tb_rsfq_and2t_driver;

    localparam int SC      = 4;
    localparam int RC      = 10;
    localparam int LAT     = SC + RC + 2;   // acceptance cycle to RESP cycle
    localparam int SPACING = SC + RC + 3;

    logic clk, rst_n, req_valid, req_ready, req_a, req_b;
    logic sfq_a, sfq_b, sfq_clk, sfq_out, rsp_valid, rsp_q, rsp_err;

    rsfq_and2t_driver #(.SETUP_CYC(SC), .RESP_CYC(RC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .sfq_a    (sfq_a),
        .sfq_b    (sfq_b),
        .sfq_clk  (sfq_clk),
        .sfq_out  (sfq_out),
        .rsp_valid(rsp_valid),
        .rsp_q    (rsp_q),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    acc_q[$];
    string cur_tag  = "init";

    // Expected pulse-line levels and held response, tracked by the bench.
    logic m_a, m_b, m_clk, last_q, last_err;

    typedef struct {
        logic        a;
        logic        b;
        logic [31:0] mask;   // bit k: sfq_out toggles in cycle k after acceptance
        logic        q;
        logic        err;
    } vec_t;

    vec_t vecs[12];
    vec_t b2b[4];

    always @(posedge clk) cyc <= cyc + 1;

    // Record acceptance cycles, sampled well after the inputs settle.
    always @(negedge clk) begin
        #2;
        if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %b expected %b at t=%0t", cur_tag, name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s/%s: got %0d expected %0d at t=%0t", cur_tag, name, act, exp, $time);
        end
    endtask

    // Reference: classify each toggle by the phase it falls in.
    function automatic void model(input logic a, input logic b, input logic [31:0] mask,
                                  output logic q, output logic err);
        int n    = 0;
        bit spur = 0;
        for (int k = 0; k <= LAT; k++) begin
            if (mask[k]) begin
                if (k <= SC + 1)          spur = 1;
                else if (k <= SC + RC + 1) n++;
            end
        end
        q   = (n > 0);
        err = (q != (a & b)) || (n >= 2) || spur;
    endfunction

    task automatic idle_checks();
        check("ready", req_ready, 1'b1);
        check("rsp_valid", rsp_valid, 1'b0);
        check("sfq_a", sfq_a, m_a);
        check("sfq_b", sfq_b, m_b);
        check("sfq_clk", sfq_clk, m_clk);
        check("rsp_q_hold", rsp_q, last_q);
        check("rsp_err_hold", rsp_err, last_err);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            idle_checks();
        end
    endtask

    // One full operation starting at the next negedge (cycle 0 = acceptance).
    task automatic run_op(input logic a, input logic b, input logic [31:0] mask,
                          input logic exp_q, input logic exp_err, input bit hold);
        @(negedge clk);
        idle_checks();
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        if (mask[0]) sfq_out = ~sfq_out;
        m_a = m_a ^ a;
        m_b = m_b ^ b;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == SC + 1) m_clk = ~m_clk;
            check("ready_busy", req_ready, 1'b0);
            check("sfq_a", sfq_a, m_a);
            check("sfq_b", sfq_b, m_b);
            check("sfq_clk", sfq_clk, m_clk);
            check("rsp_valid", rsp_valid, (k == LAT));
            if (k == LAT) begin
                check("rsp_q", rsp_q, exp_q);
                check("rsp_err", rsp_err, exp_err);
                last_q   = exp_q;
                last_err = exp_err;
            end else begin
                check("rsp_q_hold", rsp_q, last_q);
                check("rsp_err_hold", rsp_err, last_err);
            end
            // Requests offered while busy must be ignored.
            req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            req_a     = 1'($urandom_range(0, 1));
            req_b     = 1'($urandom_range(0, 1));
            if (mask[k]) sfq_out = ~sfq_out;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0}; // toggle 3 after sfq_clk
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0}; // only sfq_a, no result
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0480, 1'b1, 1'b1}; // two toggles in WAIT
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0208, 1'b1, 1'b1}; // spurious in SETUP
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_8000, 1'b1, 1'b0}; // last WAIT cycle counts
        vecs[5]  = '{1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0}; // toggle in RESP ignored
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1}; // missing result
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1}; // first WAIT cycle, wrong result
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_1001, 1'b1, 1'b1}; // spurious in IDLE at accept
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_1000, 1'b1, 1'b0}; // clean after spurious
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b1}; // spurious in CLKP
        vecs[11] = '{1'b0, 1'b0, 32'h0000_4002, 1'b1, 1'b1}; // spurious in DATA
        b2b[0]   = '{1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0};
        b2b[1]   = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        b2b[2]   = '{1'b0, 1'b1, 32'h0000_2000, 1'b1, 1'b1};
        b2b[3]   = '{1'b0, 1'b0, 32'h0000_0480, 1'b1, 1'b1};

        rst_n = 1'b0; req_valid = 1'b0; req_a = 1'b0; req_b = 1'b0; sfq_out = 1'b0;
        m_a = 1'b0; m_b = 1'b0; m_clk = 1'b0; last_q = 1'b0; last_err = 1'b0;

        cur_tag = "reset";
        repeat (3) @(negedge clk);
        idle_checks();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run_op(vecs[i].a, vecs[i].b, vecs[i].mask, vecs[i].q, vecs[i].err, 1'b0);
        end

        cur_tag = "b2b";
        acc_q.delete();
        for (int i = 0; i < 4; i++)
            run_op(b2b[i].a, b2b[i].b, b2b[i].mask, b2b[i].q, b2b[i].err, 1'b1);
        req_valid = 1'b0;
        gap(2);
        check_int("accept_count", acc_q.size(), 4);
        for (int i = 1; i < acc_q.size(); i++)
            check_int("accept_spacing", acc_q[i] - acc_q[i-1], SPACING);

        // Reset in the last SETUP cycle aborts the operation.
        cur_tag = "abort";
        @(negedge clk);
        req_valid = 1'b1; req_a = 1'b1; req_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        @(negedge clk);
        check("sfq_clk_pre", sfq_clk, m_clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_sfq_a", sfq_a, 1'b0);
        check("rst_sfq_b", sfq_b, 1'b0);
        check("rst_sfq_clk", sfq_clk, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_q", rsp_q, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        m_a = 1'b0; m_b = 1'b0; m_clk = 1'b0; last_q = 1'b0; last_err = 1'b0;
        gap(LAT + 4);

        cur_tag = "random";
        for (int i = 0; i < 20; i++) begin
            logic        a, b, q, err;
            logic [31:0] mask;
            a    = 1'($urandom_range(0, 1));
            b    = 1'($urandom_range(0, 1));
            mask = '0;
            for (int k = 0; k <= LAT; k++)
                if ($urandom_range(0, 7) == 0) mask[k] = 1'b1;
            model(a, b, mask, q, err);
            run_op(a, b, mask, q, err, 1'b0);
            gap(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsfq_and2t_driver.md
RSFQ_AND2T_DRIVER -- requirements
Module: rsfq_and2t_driver

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 4: clk cycles from data-pulse issue to sfq_clk pulse issue.
REQ-002 The block SHALL have parameter RESP_CYC, default 10: clk cycles after sfq_clk pulse during which sfq_out is observed.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have the port req_valid, input, 1 bit: an operand pair is offered.
REQ-006 The block SHALL have the port req_ready, output, 1 bit: the block accepts an operand pair.
REQ-007 The block SHALL have the ports req_a and req_b, input, 1 bit each: operands.
REQ-008 The block SHALL have the ports sfq_a, sfq_b and sfq_clk, output, 1 bit each: toggle-encoded pulse lines; each level change is one SFQ pulse.
REQ-009 The block SHALL have the port sfq_out, input, 1 bit: toggle-encoded result from the gate under drive.
REQ-010 The block SHALL have the port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-011 The block SHALL have the port rsp_q, output, 1 bit: a result pulse was observed.
REQ-012 The block SHALL have the port rsp_err, output, 1 bit: protocol or result error.

Function
REQ-013 The block SHALL implement the FSM IDLE -> DATA -> SETUP -> CLKP -> WAIT -> RESP -> IDLE.
REQ-014 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-015 req_valid and req_ready both high SHALL latch req_a/req_b and move to DATA.
REQ-016 In DATA (1 cycle), sfq_a SHALL toggle iff the latched a=1 and sfq_b SHALL toggle iff the latched b=1; both toggles SHALL occur in the same cycle.
REQ-017 SETUP SHALL last SETUP_CYC-1 cycles, so that the sfq_clk toggle occurs exactly SETUP_CYC cycles after the DATA toggle; SETUP_CYC=1 SHALL skip SETUP.
REQ-018 CLKP (1 cycle) SHALL toggle sfq_clk.
REQ-019 WAIT SHALL last RESP_CYC cycles and count sfq_out level changes, using a registered previous value.
REQ-020 RESP SHALL assert rsp_valid for exactly one cycle, with rsp_q=1 iff at least one sfq_out toggle was seen in WAIT.
REQ-021 rsp_err SHALL be 1 if any of the following holds: rsp_q differs from (a AND b); two or more toggles were seen in WAIT; sfq_out was X/Z when sampled; or a sticky spurious flag is set.
REQ-022 A sfq_out toggle in IDLE, DATA, SETUP or CLKP SHALL set the sticky spurious flag; RESP SHALL clear it after it is reported.
REQ-023 A toggle arriving in the same cycle as the WAIT->RESP transition SHALL count in WAIT.
REQ-024 req_valid outside IDLE SHALL be ignored, with no latching and no pulses.
REQ-025 rsp_q and rsp_err SHALL hold their values until the next RESP; only rsp_valid qualifies them.
REQ-026 Minimum request spacing SHALL be SETUP_CYC+RESP_CYC+3 cycles; back-to-back requests SHALL be accepted at this rate.

Reset
REQ-027 While rst_n=0 at a clk edge: state SHALL be IDLE; sfq_a, sfq_b and sfq_clk SHALL be 0; rsp_valid, rsp_q and rsp_err SHALL be 0; counters, toggle count and spurious flag SHALL be 0; the previous-sfq_out register SHALL load the current sfq_out.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no rsp_valid; pulse lines SHALL return to 0 even if this creates a level change.
REQ-029 req_ready SHALL be 1 in the first cycle after rst_n returns high.

Structure
REQ-030 Package rsfq_drv_pkg SHALL hold the state enum and the default SETUP_CYC/RESP_CYC constants.
REQ-031 Sub-module rsfq_toggle_det SHALL take clk, rst_n and a toggle line and produce a one-cycle pulse per level change plus an unknown-level flag; it SHALL be instantiated once, on sfq_out.

Verification
REQ-032 The bench SHALL cover: a=1, b=1, model toggles sfq_out 3 cycles after sfq_clk -> sfq_a/sfq_b toggle in cycle 1, sfq_clk toggles in cycle 5, rsp_valid in cycle 16 with rsp_q=1, rsp_err=0.
REQ-033 The bench SHALL cover: a=1, b=0, no sfq_out toggle -> only sfq_a toggles, rsp_q=0, rsp_err=0.
REQ-034 The bench SHALL cover: a=0, b=0, sfq_out toggles twice in WAIT -> rsp_q=1, rsp_err=1.
REQ-035 The bench SHALL cover: sfq_out toggle in SETUP, a=b=1 with a correct result -> rsp_err=1; the next clean request gives rsp_err=0.
REQ-036 The bench SHALL cover: rst_n low at cycle 3 of SETUP -> no sfq_clk toggle, no rsp_valid, and req_ready=1 on the first cycle after release.
REQ-037 The bench SHALL cover: 4 back-to-back requests with req_valid held high -> acceptances exactly 17 cycles apart (defaults), with responses in order.
